dram_arbiter: RTL and testbench

Shares the single data-RAM port of the single-cycle MIPS SoC between the CPU load/store path and a debug/DMA port used for preloading and dumping memory during simulation and bring-up. The CPU has priority and sees zero added latency when granted; the debug port gets fixed-length word bursts and is guaranteed service within a bounded wait. The block sits between the CPU data interface, the debug master and the DRAM instance, and drives a stall to hold the CPU PC while it is denied.

---
 rtl/dram_arbiter.sv | 74 +++++++
 tb/tb_dram_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the data-RAM port between the CPU (priority, zero latency) and a bounded-wait debug burst port
module dram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_WAIT = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [3:0]        dbg_len,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_gnt,
  output logic              dbg_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0] beat_q, beat_d, len_q, len_d, eff_len;
  logic [ADDR_W-1:0] base_q, base_d;
  logic we_q, we_d, dbg_win, cpu_win, burst;
  always_comb begin
    eff_len = dbg_len == 4'd0 ? 4'd1 : dbg_len > MB ? MB : dbg_len;
    burst = reset && state_q == BURST;
    dbg_win = reset && state_q == IDLE && dbg_req && (!cpu_req || wait_q == WMAX);
    cpu_win = reset && state_q == IDLE && cpu_req && !dbg_win;
    dbg_gnt = dbg_win || burst;
    dbg_done = dbg_win ? eff_len == 4'd1 : burst && beat_q == len_q - 4'd1;
    cpu_stall = reset && cpu_req && !cpu_win;
    mem_en = cpu_win || dbg_gnt;
    mem_we = cpu_win ? cpu_we : dbg_win ? dbg_we : burst && we_q;
    mem_addr = cpu_win ? cpu_addr : burst ? base_q + ADDR_W'({beat_q, 2'b00}) : dbg_addr;
    mem_wdata = cpu_win ? cpu_wdata : dbg_wdata;
    cpu_rdata = mem_rdata;
    dbg_rdata = mem_rdata;
    state_d = dbg_win && eff_len != 4'd1 ? BURST : burst && dbg_done ? IDLE : state_q;
    wait_d = (state_q == BURST || dbg_win || !dbg_req) ? '0 : wait_q == WMAX ? wait_q : wait_q + 1'b1;
    beat_d = dbg_win ? 4'd1 : burst ? beat_q + 4'd1 : beat_q;
    base_d = dbg_win ? dbg_addr : base_q;
    len_d = dbg_win ? eff_len : len_q;
    we_d = dbg_win ? dbg_we : we_q;
  end
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q <= '0;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      beat_q <= beat_d;
      base_q <= base_d;
      len_q <= len_d;
      we_q <= we_d;
    end
  end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: scoreboard bench for dram_arbiter against a small RAM model
module tb_dram_arbiter;
  typedef struct {
    string tag;
    bit en, we, ca, gnt, done, stall, cc, cd;
    logic [31:0] addr, cr, dr;
  } exp_t;
  logic clk_in = 1'b0;
  logic reset = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, dbg_addr = '0, dbg_wdata = '0;
  logic [3:0] dbg_len = '0;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic cpu_stall, dbg_gnt, dbg_done, mem_en, mem_we;
  logic [31:0] ram [0:1023];
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  dram_arbiter dut (
    .clk_in(clk_in), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );
  always #5 clk_in = ~clk_in;
  assign mem_rdata = ram[mem_addr[11:2]];
  always @(posedge clk_in) if (mem_en && mem_we) ram[mem_addr[11:2]] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  always @(negedge clk_in) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".en"}, {31'b0, mem_en}, {31'b0, e.en});
      chk({e.tag, ".we"}, {31'b0, mem_we}, {31'b0, e.we});
      chk({e.tag, ".gnt"}, {31'b0, dbg_gnt}, {31'b0, e.gnt});
      chk({e.tag, ".done"}, {31'b0, dbg_done}, {31'b0, e.done});
      chk({e.tag, ".stall"}, {31'b0, cpu_stall}, {31'b0, e.stall});
      if (e.ca) chk({e.tag, ".addr"}, mem_addr, e.addr);
      if (e.cc) chk({e.tag, ".cpu_rdata"}, cpu_rdata, e.cr);
      if (e.cd) chk({e.tag, ".dbg_rdata"}, dbg_rdata, e.dr);
    end
  end
  task automatic push(input exp_t e);
    sb.push_back(e);
    @(posedge clk_in);
    #1;
  endtask
  task automatic off_step(input string tag);
    exp_t e;
    e.tag = tag; e.en = 0; e.we = 0; e.ca = 0; e.gnt = 0; e.done = 0; e.stall = 0;
    e.cc = 0; e.cd = 0; e.addr = '0; e.cr = '0; e.dr = '0;
    push(e);
  endtask
  task automatic cpu_step(input string tag, input bit we, input logic [31:0] addr,
                          input bit cc, input logic [31:0] cr);
    exp_t e;
    e.tag = tag; e.en = 1; e.we = we; e.ca = 1; e.gnt = 0; e.done = 0; e.stall = 0;
    e.cc = cc; e.cd = 0; e.addr = addr; e.cr = cr; e.dr = '0;
    push(e);
  endtask
  task automatic dbg_step(input string tag, input bit we, input logic [31:0] addr, input bit done,
                          input bit stall, input bit cd, input logic [31:0] dr);
    exp_t e;
    e.tag = tag; e.en = 1; e.we = we; e.ca = 1; e.gnt = 1; e.done = done; e.stall = stall;
    e.cc = 0; e.cd = cd; e.addr = addr; e.cr = '0; e.dr = dr;
    push(e);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    @(posedge clk_in);
    #1;
    cpu_req = 1; dbg_req = 1; cpu_addr = 32'h40;
    off_step("rst0");
    off_step("rst1");
    reset = 1;
    cpu_step("rel_cpu_first", 0, 32'h40, 0, 0);
    dbg_req = 0; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    cpu_step("cpu_store", 1, 32'h10, 0, 0);
    cpu_we = 0;
    cpu_step("cpu_load", 0, 32'h10, 1, 32'hDEADBEEF);
    cpu_req = 0; dbg_req = 1; dbg_we = 1; dbg_addr = 32'h100; dbg_len = 4; dbg_wdata = 1;
    dbg_step("wb0", 1, 32'h100, 0, 0, 0, 0);
    dbg_req = 0; dbg_we = 0; dbg_addr = 32'hBAD0; dbg_len = 1;
    for (int i = 1; i < 4; i++) begin
      dbg_wdata = 32'(i + 1);
      dbg_step($sformatf("wb%0d", i), 1, 32'h100 + 32'(4 * i), i == 3, 0, 0, 0);
    end
    off_step("wb_idle");
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100; dbg_len = 4;
    dbg_step("rb0", 0, 32'h100, 0, 0, 1, 1);
    dbg_req = 0;
    for (int i = 1; i < 4; i++) dbg_step($sformatf("rb%0d", i), 0, 32'h100 + 32'(4 * i), i == 3, 0, 1, 32'(i + 1));
    cpu_req = 1; cpu_addr = 32'h10; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h108; dbg_len = 2;
    for (int i = 0; i < 4; i++) cpu_step($sformatf("starve%0d", i), 0, 32'h10, 1, 32'hDEADBEEF);
    dbg_step("starve_gnt0", 0, 32'h108, 0, 1, 1, 3);
    dbg_step("starve_gnt1", 0, 32'h10C, 1, 1, 1, 4);
    cpu_step("cpu_regain", 0, 32'h10, 1, 32'hDEADBEEF);
    cpu_req = 0; dbg_we = 1; dbg_addr = 32'h200; dbg_len = 0; dbg_wdata = 32'h55;
    dbg_step("len0", 1, 32'h200, 1, 0, 0, 0);
    dbg_req = 0;
    off_step("len0_idle");
    chk("len0_mem", ram[128], 32'h55);
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h100; dbg_len = 15;
    for (int i = 0; i < 8; i++) begin
      dbg_step($sformatf("len15_%0d", i), 0, 32'h100 + 32'(4 * i), i == 7, 0, 1, i < 4 ? 32'(i + 1) : 32'h0);
      dbg_req = 0;
    end
    off_step("len15_idle");
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'hFFFFFFFC; dbg_len = 2; dbg_wdata = 32'h77;
    dbg_step("wrap0", 1, 32'hFFFFFFFC, 0, 0, 0, 0);
    dbg_req = 0; dbg_wdata = 32'h78;
    dbg_step("wrap1", 1, 32'h0, 1, 0, 0, 0);
    off_step("wrap_idle");
    chk("wrap_mem_hi", ram[1023], 32'h77);
    chk("wrap_mem_lo", ram[0], 32'h78);
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h300; dbg_len = 6; dbg_wdata = 32'hA0;
    dbg_step("mid0", 1, 32'h300, 0, 0, 0, 0);
    dbg_req = 0; dbg_wdata = 32'hA1;
    dbg_step("mid1", 1, 32'h304, 0, 0, 0, 0);
    reset = 0; dbg_wdata = 32'hA2;
    off_step("mid_rst0");
    off_step("mid_rst1");
    reset = 1;
    off_step("mid_after");
    chk("mid_mem0", ram[192], 32'hA0);
    chk("mid_mem1", ram[193], 32'hA1);
    chk("mid_nowrite", ram[194], 32'h0);
    cpu_req = 1; cpu_addr = 32'h10; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h300; dbg_len = 1;
    for (int i = 0; i < 4; i++) cpu_step($sformatf("post_wait%0d", i), 0, 32'h10, 1, 32'hDEADBEEF);
    dbg_step("post_gnt", 0, 32'h300, 1, 1, 1, 32'hA0);
    cpu_req = 0; dbg_req = 0;
    off_step("final_idle");
    @(negedge clk_in);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
